mac_serial_seq: RTL
===================

Name: mac_serial_seq

Overview:
- Multi-lane bit-serial weight MAC with an integrated sequencer. It replaces external fsm_last/fsm_accu driving and external clk_accu gating.
- LANES parallel weight/activation pairs are accepted per operand. Weights are serialised internally N_WIDTH bits per cycle, LSB chunk first.
- Lane products are summed into one dot-product accumulator over acc_len operands. The result is returned through a valid/ready output handshake.
- Runtime weight precision is set by config_w, as in the existing serial MAC.

Parameters:
- W_WIDTH, 8, max weight width (signed, MSB-aligned, zero-padded LSBs)
- A_WIDTH, 8, activation width (unsigned)
- N_WIDTH, 2, weight bits processed per cycle; divides W_WIDTH
- PLUS_WIDTH, 4, accumulation guard bits
- LANES, 4, parallel weight/activation pairs per operand
- CONFIG_W_WIDTH, 2, precision config width
- ACC_LEN_WIDTH, 8, width of accumulation-length input
- Z_WIDTH (local), W_WIDTH+A_WIDTH+PLUS_WIDTH+$clog2(LANES) = 22 at defaults

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- config_w  in  CONFIG_W_WIDTH  active weight width = max(W_WIDTH>>config_w, N_WIDTH)
- acc_len  in  ACC_LEN_WIDTH  operands per accumulation group; 0 treated as 1
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid&in_ready at posedge
- w  in  LANES*W_WIDTH  weights; lane i = w[i*W_WIDTH +: W_WIDTH], signed, MSB-aligned
- a  in  LANES*A_WIDTH  activations, unsigned
- out_valid  out  1  z holds a completed group result
- out_ready  in  1  result consumed when out_valid&out_ready at posedge
- z  out  Z_WIDTH  signed dot-product result, LSB-aligned (not shifted by precision)

Behaviour:
- Reset (rst=0, async): state=IDLE; in_ready=0, out_valid=0, z=0; accumulator, digit counter and operand counter cleared.
- K = active_width/N_WIDTH digit cycles per operand; K=4 at config_w=0 with defaults.
- Only the top active_width bits of each lane weight are used. Lower bits are ignored.
- config_w and acc_len are latched on the first accepted operand of a group. Later changes within the group are ignored.
- FSM states:
  - IDLE: in_ready=1. On accept, latch w/a into lane shift registers, digit=0, go SER.
  - SER: each cycle, every lane adds digit*a << (digit_idx*N_WIDTH) to its partial product. The last chunk (digit_idx=K-1) is treated as a signed N_WIDTH digit; all other chunks are unsigned.
  - SER, last digit cycle: the sum of all lane products is added to the accumulator. in_ready=1 during this cycle, which allows back-to-back operands at one operand per K cycles.
    - If operand_count==acc_len-1, go OUT and ignore in_valid (in_ready=0).
    - Else, if an operand is accepted, restart SER; otherwise go IDLE.
  - OUT: out_valid=1, in_ready=0. z = accumulator, held stable while out_ready=0. On out_ready, clear accumulator and operand counter and go IDLE; out_valid deasserts the next cycle.
- Latency: a single-operand group raises out_valid exactly K cycles after the accept edge.
- Arithmetic: full products are sign-extended to Z_WIDTH. The accumulator wraps modulo 2^Z_WIDTH unless the optional feature is enabled.
- A z update and out_valid become visible together. z is never updated while out_valid=1.
- Reset mid-SER or in OUT aborts the group with no partial result.

Optional Feature:
- Macro MAC_SERIAL_SAT_EN.
- Defined: each accumulator add saturates to [-2^(Z_WIDTH-1), 2^(Z_WIDTH-1)-1]. Once saturated, the value stays clamped until the group is consumed.
- Undefined: two's-complement wrap; no saturation logic is synthesised.

Test Plan:
- Full precision, single operand: config_w=0, acc_len=1, all lanes w=8'hFF (-1), a=255 → out_valid exactly 4 cycles after accept; z=-1020.
- Reduced precision: config_w=1 (4-bit), acc_len=1, lane0 w=8'h70 (+7), a=10, other lanes w=0 → out_valid after 2 cycles; z=70. Repeat with lane0 w=8'h7F → low nibble ignored, z=70.
- Back-to-back: config_w=0, acc_len=3, in_valid held high, lane0 (w,a) = (8'h03,5), (8'hFE,7), (8'h10,2), others w=0 → in_ready pulses on each last digit cycle; operands accepted 4 cycles apart; z=15-14+32=33.
- Output backpressure: hold out_ready=0 for 5 cycles after out_valid → z stable, in_ready=0, new in_valid ignored. Then out_ready=1 → IDLE; next group starts from accumulator 0.
- Async reset mid-SER: drop rst on digit 2 of a 4-digit operand → in_ready, out_valid and z go 0 immediately without a clock edge. After release, a fresh acc_len=1 group gives the correct result.
- Overflow: acc_len=20, all lanes w=8'h7F, a=255 (129540 per operand) → with MAC_SERIAL_SAT_EN z=2097151; without it z=-1603504.

Source files
------------

// File: rtl/mac_serial_seq.sv
// Multi-lane bit-serial weight MAC with an integrated operand sequencer.
// Each operand carries LANES weight/activation pairs. Weights are consumed
// N_WIDTH bits per cycle, LSB chunk first, and the chunk at the top of the
// active width is signed. Lane products are summed into one dot-product
// accumulator over acc_len operands, and the group result is presented on a
// valid/ready output.
// Optional build macro MAC_SERIAL_SAT_EN: the accumulator saturates and stays
// clamped until the group is consumed. When it is undefined the accumulator
// wraps in two's complement.
//
// state | meaning
// IDLE  | waiting for an operand; in_ready=1
// SER   | serialising weight chunks; in_ready=1 only on a non-final last digit
// OUT   | group result on z, out_valid=1, waiting for out_ready
module mac_serial_seq #(
    parameter int W_WIDTH        = 8,
    parameter int A_WIDTH        = 8,
    parameter int N_WIDTH        = 2,
    parameter int PLUS_WIDTH     = 4,
    parameter int LANES          = 4,
    parameter int CONFIG_W_WIDTH = 2,
    parameter int ACC_LEN_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CONFIG_W_WIDTH-1:0]   config_w,
    input  logic [ACC_LEN_WIDTH-1:0]    acc_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*W_WIDTH-1:0]    w,
    input  logic [LANES*A_WIDTH-1:0]    a,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [W_WIDTH+A_WIDTH+PLUS_WIDTH+$clog2(LANES)-1:0] z
);

    localparam int Z_WIDTH = W_WIDTH + A_WIDTH + PLUS_WIDTH + $clog2(LANES);
    localparam int K_MAX   = W_WIDTH / N_WIDTH;
    localparam int DIG_W   = $clog2(K_MAX + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SER  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]                state;
    logic [DIG_W-1:0]          digit;
    logic [ACC_LEN_WIDTH-1:0]  op_cnt;
    logic [ACC_LEN_WIDTH-1:0]  len_m1_q;
    logic [CONFIG_W_WIDTH-1:0] cfg_q;
    logic                      run_q;
    logic [W_WIDTH-1:0]        w_sh   [LANES];
    logic signed [Z_WIDTH-1:0] a_sc   [LANES];
    logic signed [Z_WIDTH-1:0] part   [LANES];
    logic signed [Z_WIDTH-1:0] acc;

    logic                      first_op, last_dig, last_op, accept;
    logic [DIG_W-1:0]          k_last;
    int                        load_shift;
    logic [W_WIDTH-1:0]        w_load    [LANES];
    logic signed [Z_WIDTH-1:0] part_next [LANES];
    logic signed [Z_WIDTH-1:0] total;
    logic signed [Z_WIDTH-1:0] acc_next;

    function automatic int active_width(input logic [CONFIG_W_WIDTH-1:0] c);
        int aw;
        aw = W_WIDTH >> c;
        if (aw < N_WIDTH) aw = N_WIDTH;
        return aw;
    endfunction

    // Sequencer decode: digit/operand terminal counts and handshake signals.
    // run_q keeps in_ready low until the first clock after reset release.
    always_comb begin
        k_last     = DIG_W'(active_width(cfg_q) / N_WIDTH - 1);
        last_dig   = (state == SER) && (digit == k_last);
        last_op    = (op_cnt == len_m1_q);
        first_op   = (state == IDLE) && (op_cnt == '0);
        in_ready   = run_q && ((state == IDLE) || (last_dig && !last_op));
        accept     = in_valid && in_ready;
        out_valid  = (state == OUT);
        load_shift = W_WIDTH - active_width(first_op ? config_w : cfg_q);
    end

    // Lane datapath: align the active weight bits to the LSB on load, and add
    // this cycle's chunk times the pre-shifted activation to each partial.
    always_comb begin
        logic [N_WIDTH-1:0]        chunk;
        logic signed [Z_WIDTH-1:0] dig;
        total = '0;
        for (int i = 0; i < LANES; i++) begin
            w_load[i]    = w[i*W_WIDTH +: W_WIDTH] >> load_shift;
            chunk        = w_sh[i][N_WIDTH-1:0];
            dig          = {{(Z_WIDTH-N_WIDTH){last_dig & chunk[N_WIDTH-1]}}, chunk};
            part_next[i] = part[i] + dig * a_sc[i];
            total        = total + part_next[i];
        end
    end

`ifdef MAC_SERIAL_SAT_EN
    logic                      sat_q;
    logic                      sat_next;
    logic signed [Z_WIDTH:0]   acc_wide;

    // Saturating accumulate; once clamped the value is frozen for the group.
    always_comb begin
        acc_wide = {acc[Z_WIDTH-1], acc} + {total[Z_WIDTH-1], total};
        acc_next = acc_wide[Z_WIDTH-1:0];
        sat_next = sat_q;
        if (sat_q) begin
            acc_next = acc;
        end else if (acc_wide[Z_WIDTH] != acc_wide[Z_WIDTH-1]) begin
            sat_next = 1'b1;
            acc_next = acc_wide[Z_WIDTH] ? {1'b1, {(Z_WIDTH-1){1'b0}}}
                                         : {1'b0, {(Z_WIDTH-1){1'b1}}};
        end
    end

    // Sticky saturation flag, cleared when the group result is consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                     sat_q <= 1'b0;
        else if (state == OUT && out_ready)           sat_q <= 1'b0;
        else if (last_dig)                            sat_q <= sat_next;
    end
`else
    // Wrapping accumulate.
    always_comb begin
        acc_next = acc + total;
    end
`endif

    // Main sequencer and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            digit    <= '0;
            op_cnt   <= '0;
            len_m1_q <= '0;
            cfg_q    <= '0;
            acc      <= '0;
            z        <= '0;
            run_q    <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                w_sh[i] <= '0;
                a_sc[i] <= '0;
                part[i] <= '0;
            end
        end else begin
            run_q <= 1'b1;
            case (state)
                IDLE: ;
                SER: begin
                    digit <= digit + DIG_W'(1);
                    for (int i = 0; i < LANES; i++) begin
                        w_sh[i] <= w_sh[i] >> N_WIDTH;
                        a_sc[i] <= a_sc[i] <<< N_WIDTH;
                        part[i] <= part_next[i];
                    end
                    if (last_dig) begin
                        acc <= acc_next;
                        if (last_op) begin
                            z     <= acc_next;
                            state <= OUT;
                        end else begin
                            op_cnt <= op_cnt + ACC_LEN_WIDTH'(1);
                            state  <= IDLE;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc    <= '0;
                        op_cnt <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // An accepted operand overrides the SER bookkeeping above.
            if (accept) begin
                state <= SER;
                digit <= '0;
                for (int i = 0; i < LANES; i++) begin
                    w_sh[i] <= w_load[i];
                    a_sc[i] <= {{(Z_WIDTH-A_WIDTH){1'b0}}, a[i*A_WIDTH +: A_WIDTH]};
                    part[i] <= '0;
                end
                if (first_op) begin
                    cfg_q    <= config_w;
                    len_m1_q <= (acc_len == '0) ? '0 : acc_len - ACC_LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule
